// File: rtl/instr_controller.sv
// Instruction register, decoder and control FSM for the SRM datapath.
// Latches a 16-bit instruction and sequences read, execute and write-back cycles.
module instr_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_GET_A     = 3'd2;
    localparam logic [2:0] S_GET_B     = 3'd3;
    localparam logic [2:0] S_EXEC      = 3'd4;
    localparam logic [2:0] S_WRITE_REG = 3'd5;
    localparam logic [2:0] S_WRITE_IMM = 3'd6;

    logic [2:0]  state_reg, state_next;
    logic [15:0] ir_reg;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign rm     = ir_reg[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // IR only accepts a new word while idle, so it is stable for a whole instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_WAIT;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (load && (state_reg == S_WAIT))
                ir_reg <= in;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT:      if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_next = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_next = S_GET_B;
                else if (is_alu)               state_next = S_GET_A;
                else                           state_next = S_WAIT;
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_EXEC;
            S_EXEC:      state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            S_WRITE_IMM: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    assign shift  = ir_reg[4:3];
    assign sximm8 = {{8{ir_reg[7]}}, ir_reg[7:0]};
    // MOV reg computes 0 + shifted B, so only the ALU group passes op through.
    assign ALUop  = is_alu ? op : 2'b00;
    assign bsel   = 1'b0;

    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        case (state_reg)
            S_WAIT:  w = 1'b1;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                loadc = ~is_cmp;
                loads = 1'b1;
                asel  = is_mov_reg || is_mvn;
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                vsel     = 2'b00;
                writenum = rd;
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                vsel     = 2'b10;
                writenum = rn;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_controller.sv
// Randomised bench for instr_controller: an instruction-level model predicts
// the per-cycle output vector of each instruction and a compare process checks it.
module tb_instr_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8;

    instr_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
        .ALUop(ALUop), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
    } outv_t;

    outv_t act;
    always_comb act = {w, readnum, writenum, write, vsel, loada, loadb,
                       loadc, loads, asel, bsel, shift, ALUop, sximm8};

    int    total = 0;
    int    bad   = 0;
    bit    chk_en = 1'b0;
    logic [15:0] model_ir;
    outv_t exp_q[$];
    outv_t trace [0:7];

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Outputs every cycle has in common: IR-derived fields, all strobes low.
    function automatic outv_t base_vec(input logic [15:0] ir, input bit idle);
        outv_t v;
        v = '0;
        v.w      = idle;
        v.shift  = ir[4:3];
        v.aluop  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        v.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return v;
    endfunction

    // Push one expected vector per non-idle cycle of the instruction; returns count.
    function automatic int push_seq(input logic [15:0] ir);
        outv_t b, v;
        logic [2:0] opc;
        logic [1:0] op;
        opc = ir[15:13];
        op  = ir[12:11];
        b   = base_vec(ir, 1'b0);
        exp_q.push_back(b);
        if (opc == 3'b110 && op == 2'b10) begin
            v = b; v.write = 1; v.vsel = 2'b10; v.writenum = ir[10:8];
            exp_q.push_back(v);
            return 2;
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            v = b; v.readnum = ir[2:0]; v.loadb = 1; exp_q.push_back(v);
            v = b; v.loadc = 1; v.loads = 1; v.asel = 1; exp_q.push_back(v);
            v = b; v.write = 1; v.writenum = ir[7:5]; exp_q.push_back(v);
            return 4;
        end else if (opc == 3'b101) begin
            v = b; v.readnum = ir[10:8]; v.loada = 1; exp_q.push_back(v);
            v = b; v.readnum = ir[2:0];  v.loadb = 1; exp_q.push_back(v);
            v = b; v.loadc = (op != 2'b01); v.loads = 1; exp_q.push_back(v);
            if (op == 2'b01) return 4;
            v = b; v.write = 1; v.writenum = ir[7:5]; exp_q.push_back(v);
            return 5;
        end
        return 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (exp_q.size() != 0) chk("cycle", act, exp_q.pop_front());
            else                   chk("idle", act, base_vec(model_ir, 1'b1));
        end
    end

    task automatic idle(input int n, input bit rnd_load);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            s = 1'b0;
            load = rnd_load ? 1'($urandom_range(0, 1)) : 1'b0;
            in = 16'($urandom);
            @(posedge clk);
            if (load) model_ir = in;
        end
    endtask

    // Starts an instruction from WAIT and walks it to completion.
    task automatic run(input logic [15:0] instr, input bit rnd, output int len);
        @(negedge clk); #1;
        in = instr; load = 1'b1; s = 1'b1;
        @(posedge clk);
        model_ir = instr;
        len = push_seq(instr);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            trace[i] = act;
            #1;
            s    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            load = rnd ? 1'b1 : 1'b0;
            in   = rnd ? 16'($urandom) : 16'h0000;
            @(posedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        logic [15:0] instr;
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
        model_ir = 16'h0;
        #1;
        chk("rst_w", 36'(w), 36'(1));
        chk("rst_vec", act, base_vec(16'h0, 1'b1));
        @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1'b1;

        run(16'hD32A, 1'b1, len);
        chk("movimm_len", 36'(len), 36'(2));
        chk("movimm_write", {trace[1].write, trace[1].vsel, trace[1].writenum}, {1'b1, 2'b10, 3'd3});
        chk("movimm_imm", 36'(trace[1].sximm8), 36'(42));
        run(16'hD50D, 1'b0, len);
        chk("movimm2", {trace[1].writenum, trace[1].sximm8}, {3'd5, 16'd13});

        run(16'hA543, 1'b0, len);
        chk("add_len", 36'(len), 36'(5));
        chk("add_geta", {trace[1].readnum, trace[1].loada}, {3'd5, 1'b1});
        chk("add_getb", {trace[2].readnum, trace[2].loadb}, {3'd3, 1'b1});
        chk("add_exec", {trace[3].aluop, trace[3].shift, trace[3].loadc, trace[3].loads}, {4'b0000, 2'b11});
        chk("add_wr", {trace[4].write, trace[4].writenum, trace[4].vsel}, {1'b1, 3'd2, 2'b00});

        run(16'hC093, 1'b0, len);
        chk("movreg_getb", {trace[1].readnum, trace[1].loadb}, {3'd3, 1'b1});
        chk("movreg_exec", {trace[2].asel, trace[2].shift, trace[2].aluop}, {1'b1, 2'b10, 2'b00});
        chk("movreg_wr", {trace[3].write, trace[3].writenum}, {1'b1, 3'd4});

        run(16'hAB05, 1'b0, len);
        chk("cmp_len", 36'(len), 36'(4));
        chk("cmp_exec", {trace[3].loads, trace[3].loadc, trace[3].aluop}, {1'b1, 1'b0, 2'b01});
        chk("cmp_nowrite", 36'(trace[0].write | trace[1].write | trace[2].write | trace[3].write), 36'(0));

        run(16'hE000, 1'b1, len);
        chk("unsup", {len[3:0], trace[0].w, trace[0].write, trace[0].loada, trace[0].loadb,
                      trace[0].loadc, trace[0].loads}, {4'd1, 6'b0});
        idle(2, 1'b0);

        // Abort an ADD in EXEC with an asynchronous reset.
        chk_en = 1'b0;
        @(negedge clk); #1;
        in = 16'hA543; load = 1'b1; s = 1'b1;
        @(posedge clk); #1; load = 1'b0; s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_exec", {loadc, loads, w}, {1'b1, 1'b1, 1'b0});
        #2; reset = 1'b1; #1;
        chk("rst_abort", act, base_vec(16'h0, 1'b1));
        @(posedge clk); #2;
        reset = 1'b0;
        model_ir = 16'h0;
        exp_q.delete();
        chk_en = 1'b1;
        idle(3, 1'b0);

        for (int n = 0; n < 300; n++) begin
            instr = 16'($urandom);
            case ($urandom_range(0, 3))
                0: instr[15:13] = 3'b101;
                1: instr[15:13] = 3'b110;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b1);
            run(instr, 1'b1, len);
        end
        idle(3, 1'b0);
        chk_en = 1'b0;
        chk("queue_drained", 36'(exp_q.size()), 36'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
# instr_controller

Instruction register, decoder and control FSM that drives the SRM datapath's control inputs. It sits on the control side of the datapath. It latches a 16-bit instruction, decodes the register indices, immediate, shift, ALU operation and write-back source, and steps the datapath through read, execute and write-back cycles. It is the initiator counterpart of the datapath's control port.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces WAIT, clears IR
- s  in  1  start; sampled only in WAIT
- load  in  1  IR load enable; honoured only while w=1
- in  in  16  instruction word
- w  out  1  1 only in WAIT (idle / ready for next instruction)
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write strobe
- vsel  out  2  write-back source: 00=C (datapath_out), 10=sximm8; 01/11 never driven
- loada, loadb, loadc, loads  out  1 each  datapath register strobes
- asel  out  1  1 forces A operand to zero
- bsel  out  1  B operand select; always 0 for this instruction set
- shift  out  2  IR[4:3]: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 MVN
- sximm8  out  16  IR[7:0] sign-extended

## Operation
- Encoding: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
- Supported: MOV Rn,#imm8 (110/10); MOV Rd,Rm{,sh} (110/00); ADD (101/00); CMP (101/01); AND (101/10); MVN Rd,Rm{,sh} (101/11). All other opcode/op pairs are unsupported.
- IR: 16-bit register, loaded from `in` on a clk edge when load=1 and state=WAIT. It holds its value otherwise.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
- Transitions:
  - WAIT: s=1 -> DECODE, else stay.
  - DECODE: MOV imm -> WRITE_IMM; MOV reg/MVN -> GET_B; ADD/CMP/AND -> GET_A; unsupported -> WAIT.
  - GET_A -> GET_B -> EXEC.
  - EXEC: CMP -> WAIT; all others -> WRITE_REG.
  - WRITE_REG -> WAIT.
  - WRITE_IMM -> WAIT.
- Moore outputs decoded from state (and IR). Every strobe is 0 unless listed:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC: loadc=1 (except CMP), loads=1; asel=1 for MOV reg and MVN.
  - WRITE_REG: write=1, vsel=00, writenum=Rd.
  - WRITE_IMM: write=1, vsel=10, writenum=Rn.
- ALUop: 00 for MOV reg (A=0 + shifted B); op for opcode 101.
- shift and sximm8 are driven continuously from IR.
- readnum/writenum are 0 in states that do not use them.
- Strobes are mutually exclusive per state. Only loadc/loads coincide, in EXEC.

## Timing
- Reset (async, immediate): state=WAIT, IR=0, w=1, all strobes 0, readnum=writenum=vsel=0, shift=00, ALUop=00, sximm8=0.
- Reset asserted mid-instruction aborts it within the same cycle; no write occurs after reset asserts.
- Latency from the s-sampling edge to the return to WAIT (edges):
  - MOV imm: 3.
  - MOV reg/MVN: 5.
  - ADD/AND: 6.
  - CMP: 5.
  - Unsupported: 2.
- Handshake: s is ignored outside WAIT. s held high makes back-to-back instructions start on the edge after w returns to 1.
- load and s may both be 1 in the same WAIT cycle: IR loads on that edge and DECODE uses the new IR.
- load while w=0 is ignored; IR is stable for the whole instruction.

## Test plan
- Reset mid-EXEC of an ADD -> w=1 and all strobes 0 asynchronously; IR reads 0; no write strobe afterwards.
- Load 0xD32A, then s; then load 0xD50D, then s -> each takes 3 edges with one WRITE_IMM cycle: write=1, vsel=10, writenum=3, sximm8=42, then writenum=5, sximm8=13.
- Load 0xA543 (ADD R2,R5,R3) -> state sequence:
  - GET_A: readnum=5, loada.
  - GET_B: readnum=3, loadb.
  - EXEC: ALUop=00, shift=00, loadc+loads.
  - WRITE_REG: writenum=2, vsel=00.
  - With the datapath attached, R2=55.
- Load 0xC093 (MOV R4,R3,LSR#1) -> GET_B with readnum=3; EXEC with asel=1, shift=10, ALUop=00; WRITE_REG with writenum=4. With R3=42, R4=21.
- Load 0xAB05 (CMP R3,R5) -> EXEC asserts loads=1, loadc=0, ALUop=01; no write strobe; w=1 five edges after s.
- Load 0xE000 (unsupported) -> DECODE then WAIT; no strobe asserted. Also: load pulsed while w=0 leaves IR unchanged.
